// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core: sequencer states, opcode fields, ALU/WB encodings.
// Pure declarations; no timing or flow-control behaviour of its own.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // Opcode class, IR[15:14]
  localparam logic [1:0] OP_LD = 2'b00;
  localparam logic [1:0] OP_ST = 2'b01;
  localparam logic [1:0] OP_2  = 2'b10;
  localparam logic [1:0] OP_3  = 2'b11;

  // op2 sub-operation, IR[13:11]
  localparam logic [2:0] OP2_LI  = 3'b000;
  localparam logic [2:0] OP2_BR  = 3'b100;
  localparam logic [2:0] OP2_BCC = 3'b111;

  // Branch condition codes, IR[10:8]
  localparam logic [2:0] CC_BE  = 3'b000;
  localparam logic [2:0] CC_BLT = 3'b001;
  localparam logic [2:0] CC_BLE = 3'b010;
  localparam logic [2:0] CC_BNE = 3'b011;

  // ALU function codes, IR[7:4]
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] FN_LAST_WR = 4'b1011;
  localparam logic [3:0] FN_HLT     = 4'b1111;

  // Write-back mux select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;

  // Flag register bit positions, {S,Z,C,V}
  localparam int FLG_S = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [3:0] {
    IC_ALU,
    IC_ALU_NOP,
    IC_HLT,
    IC_LD,
    IC_ST,
    IC_LI,
    IC_BR,
    IC_BCC,
    IC_NOP
  } iclass_t;

  function automatic iclass_t decode_class(input logic [15:0] ir);
    iclass_t cls;
    cls = IC_NOP;
    unique case (ir[15:14])
      OP_LD: cls = IC_LD;
      OP_ST: cls = IC_ST;
      OP_3: begin
        if (ir[7:4] == FN_HLT)          cls = IC_HLT;
        else if (ir[7:4] > FN_LAST_WR)  cls = IC_ALU_NOP;
        else                            cls = IC_ALU;
      end
      default: begin
        unique case (ir[13:11])
          OP2_LI:  cls = IC_LI;
          OP2_BR:  cls = IC_BR;
          OP2_BCC: cls = IC_BCC;
          default: cls = IC_NOP;
        endcase
      end
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: cond[2:0] against flags {S,Z,C,V}.
// Purely combinational, zero latency, no flow control.
module branch_cond
  import core_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic flag_s;
  logic flag_z;
  logic flag_v;
  logic lt;
  logic unused_carry;

  assign flag_s       = flags[FLG_S];
  assign flag_z       = flags[FLG_Z];
  assign flag_v       = flags[FLG_V];
  assign unused_carry = flags[FLG_C];
  assign lt           = flag_s ^ flag_v;

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      CC_BE:   taken = flag_z;
      CC_BLT:  taken = lt;
      CC_BLE:  taken = flag_z | lt;
      CC_BNE:  taken = ~flag_z;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns IR, flags and state; 2-5 cycles per instruction.
// Waits in FETCH/MEM while MEM_READY is low, holding requests stable; RESET overrides everything.
module exec_sequencer
  import core_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [15:0] INSTR,
  input  logic        MEM_READY,
  input  logic [3:0]  FLAGS_IN,
  output logic        PC_WE,
  output logic        PC_SEL,
  output logic        MEM_RE,
  output logic        MEM_WE,
  output logic        RF_WE,
  output logic [1:0]  WB_SEL,
  output logic [3:0]  S_ALU,
  output logic        HALTED
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic [3:0]  flags;
  iclass_t     icls;
  logic        cond_taken;
  logic        br_taken;
  logic        unused_ir;

  assign icls      = decode_class(ir);
  assign br_taken  = (icls == IC_BR) | ((icls == IC_BCC) & cond_taken);
  assign unused_ir = ^ir[3:0];

  branch_cond u_branch_cond (
    .cond  (ir[10:8]),
    .flags (flags),
    .taken (cond_taken)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= ST_IDLE;
      ir    <= '0;
      flags <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && MEM_READY) begin
        ir <= INSTR;
      end
      if (state == ST_EXEC && icls == IC_ALU) begin
        flags <= FLAGS_IN;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    PC_WE     = 1'b0;
    PC_SEL    = 1'b0;
    MEM_RE    = 1'b0;
    MEM_WE    = 1'b0;
    RF_WE     = 1'b0;
    WB_SEL    = WB_ALU;
    S_ALU     = ALU_ADD;
    HALTED    = 1'b0;

    unique case (state)
      ST_IDLE: state_nxt = ST_FETCH;

      ST_FETCH: begin
        MEM_RE = 1'b1;
        // PC advances only on the completing edge, so a stalled fetch still increments it once
        PC_WE  = MEM_READY;
        if (MEM_READY) begin
          state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        unique case (icls)
          IC_NOP:  state_nxt = ST_FETCH;
          IC_HLT:  state_nxt = ST_HALT;
          default: state_nxt = ST_EXEC;
        endcase
      end

      ST_EXEC: begin
        state_nxt = ST_FETCH;
        unique case (icls)
          IC_ALU: begin
            S_ALU     = ir[7:4];
            state_nxt = ST_WB;
          end
          IC_ALU_NOP: S_ALU = ir[7:4];
          IC_LI: begin
            RF_WE  = 1'b1;
            WB_SEL = WB_IMM;
          end
          IC_BR, IC_BCC: begin
            PC_WE  = br_taken;
            PC_SEL = br_taken;
          end
          IC_LD, IC_ST: begin
            S_ALU     = ALU_ADD;
            state_nxt = ST_MEM;
          end
          default: state_nxt = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        if (icls == IC_LD) begin
          MEM_RE = 1'b1;
        end else begin
          MEM_WE = 1'b1;
        end
        if (MEM_READY) begin
          state_nxt = (icls == IC_LD) ? ST_WB : ST_FETCH;
        end
      end

      ST_WB: begin
        RF_WE     = 1'b1;
        WB_SEL    = (icls == IC_LD) ? WB_MEM : WB_ALU;
        state_nxt = ST_FETCH;
      end

      ST_HALT: HALTED = 1'b1;

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
